// File: rtl/servo_pwm_gen_pkg.sv
// rtl/servo_pwm_gen_pkg.sv - shared servo constants, widths and calc FSM state type
//
// Purpose: single home for the servo timing defaults (also used by the UI
// angle block) plus the state encoding of the width calculator.
// Ports: none (package).

package servo_pwm_gen_pkg;

  // Angle range shared with the front-panel UI.
  localparam int unsigned DEF_MAX_ANGLE    = 180;
  localparam int unsigned DEF_MIN_ANGLE    = 0;

  // Pulse and frame timing, microseconds.
  localparam int unsigned DEF_MIN_PULSE_US = 500;
  localparam int unsigned DEF_MAX_PULSE_US = 2500;
  localparam int unsigned DEF_FRAME_US     = 20000;
  localparam int unsigned DEF_NEUTRAL_US   = 1500;

  // Datapath widths: 8-bit angle x 12-bit range -> 20-bit product.
  localparam int unsigned ANGLE_W = 8;
  localparam int unsigned WIDTH_W = 12;
  localparam int unsigned PROD_W  = 20;

  typedef enum logic [1:0] {
    CALC_IDLE,
    CALC_MUL,
    CALC_DIV,
    CALC_DONE
  } calc_state_e;

  // Saturate an angle command at the full-scale angle.
  function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] angle,
                                                     input int unsigned max_angle);
    if (32'(angle) > max_angle) begin
      return ANGLE_W'(max_angle);
    end
    return angle;
  endfunction

endpackage

// File: rtl/servo_width_calc.sv
// rtl/servo_width_calc.sv - angle to pulse width converter (clamp, multiply, restoring divide, offset)
//
// Purpose: width = MIN_PULSE_US + floor(min(angle,MAX_ANGLE)*(MAX-MIN)/MAX_ANGLE).
// One multiply clock, PROD_W restoring-divide clocks (one quotient bit each),
// then a one-clock done. oDone rises 21 clocks after iStart.
// Ports:
//   Clk       in   system clock
//   iRst_n    in   synchronous active-low reset (aborts any computation)
//   iStart    in   start strobe; restarts the computation if already busy
//   iAngle    in   angle, degrees (latched on iStart)
//   oDone     out  one-clock strobe, oWidthUs valid while high
//   oWidthUs  out  computed pulse width, us

module servo_width_calc
  import servo_pwm_gen_pkg::*;
#(
  parameter int unsigned MAX_ANGLE    = DEF_MAX_ANGLE,
  parameter int unsigned MIN_PULSE_US = DEF_MIN_PULSE_US,
  parameter int unsigned MAX_PULSE_US = DEF_MAX_PULSE_US
) (
  input  logic               Clk,
  input  logic               iRst_n,
  input  logic               iStart,
  input  logic [ANGLE_W-1:0] iAngle,
  output logic               oDone,
  output logic [WIDTH_W-1:0] oWidthUs
);

  localparam int unsigned          DIV_STEPS = PROD_W;
  localparam int unsigned          CNT_W     = $clog2(DIV_STEPS);
  localparam logic [ANGLE_W-1:0]   DIVISOR   = ANGLE_W'(MAX_ANGLE);
  localparam logic [WIDTH_W-1:0]   RANGE_US  = WIDTH_W'(MAX_PULSE_US - MIN_PULSE_US);
  localparam logic [WIDTH_W-1:0]   OFFSET_US = WIDTH_W'(MIN_PULSE_US);

  calc_state_e        state_q, state_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  // Dividend shifts out of the top while quotient bits enter at the bottom.
  logic [PROD_W-1:0]  quo_q, quo_d;
  logic [ANGLE_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ANGLE_W:0]   rem_shift;

  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    // Remainder stays below the divisor, so one extra bit holds the shifted value.
    rem_shift = {rem_q, quo_q[PROD_W-1]};

    if (iStart) begin
      state_d = CALC_MUL;
      angle_d = clamp_angle(iAngle, MAX_ANGLE);
    end else begin
      case (state_q)
        CALC_IDLE: begin
          state_d = CALC_IDLE;
        end
        CALC_MUL: begin
          quo_d   = PROD_W'(angle_q) * PROD_W'(RANGE_US);
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC_DIV;
        end
        CALC_DIV: begin
          if (rem_shift >= {1'b0, DIVISOR}) begin
            rem_d = ANGLE_W'(rem_shift - {1'b0, DIVISOR});
            quo_d = {quo_q[PROD_W-2:0], 1'b1};
          end else begin
            rem_d = rem_shift[ANGLE_W-1:0];
            quo_d = {quo_q[PROD_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
            state_d = CALC_DONE;
          end
        end
        CALC_DONE: begin
          state_d = CALC_IDLE;
        end
        default: begin
          state_d = CALC_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!iRst_n) begin
      state_q <= CALC_IDLE;
      angle_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // Quotient never exceeds the range, so the low WIDTH_W bits carry it all.
  assign oDone    = (state_q == CALC_DONE);
  assign oWidthUs = OFFSET_US + quo_q[WIDTH_W-1:0];

endmodule

// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - hobby-servo PWM generator, one pulse per frame
//
// Purpose: us timebase, per-frame angle sampling, width conversion and
// registered PWM compare. Angle/enable are captured one us before the frame
// boundary; the computed width becomes active exactly at the boundary.
// Ports:
//   Clk       in   system clock
//   iRst_n    in   synchronous active-low reset
//   iAngle    in   commanded angle, degrees (clamped at MAX_ANGLE)
//   iEnable   in   1 = emit pulses, 0 = frame runs with oPwm low
//   oPwm      out  servo PWM, registered
//   oFrame    out  one-clock strobe on the first clock of each frame
//   oWidthUs  out  pulse width applied in the current frame, us

module servo_pwm_gen
  import servo_pwm_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned FRAME_US     = DEF_FRAME_US,
  parameter int unsigned MIN_PULSE_US = DEF_MIN_PULSE_US,
  parameter int unsigned MAX_PULSE_US = DEF_MAX_PULSE_US,
  parameter int unsigned MAX_ANGLE    = DEF_MAX_ANGLE,
  parameter int unsigned NEUTRAL_US   = DEF_NEUTRAL_US
) (
  input  logic               Clk,
  input  logic               iRst_n,
  input  logic [ANGLE_W-1:0] iAngle,
  input  logic               iEnable,
  output logic               oPwm,
  output logic               oFrame,
  output logic [WIDTH_W-1:0] oWidthUs
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1_000_000;
  localparam int unsigned PRE_W    = $clog2(TICK_DIV);
  localparam int unsigned US_W     = $clog2(FRAME_US);

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [US_W-1:0]    us_q, us_d;
  logic               pwm_q, pwm_d;
  logic               frame_q, frame_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               en_q, en_d;
  // Pending values, captured at the sample point and applied at the boundary.
  logic [WIDTH_W-1:0] pend_width_q, pend_width_d;
  logic               pend_en_q, pend_en_d;

  logic               tick;
  logic               sample;
  logic               boundary;
  logic               calc_done;
  logic [WIDTH_W-1:0] calc_width;

  assign tick     = (pre_q == PRE_W'(TICK_DIV - 1));
  assign sample   = (pre_q == '0) && (us_q == US_W'(FRAME_US - 1));
  assign boundary = (pre_q == '0) && (us_q == '0);

  servo_width_calc #(
    .MAX_ANGLE    (MAX_ANGLE),
    .MIN_PULSE_US (MIN_PULSE_US),
    .MAX_PULSE_US (MAX_PULSE_US)
  ) u_calc (
    .Clk      (Clk),
    .iRst_n   (iRst_n),
    .iStart   (sample),
    .iAngle   (iAngle),
    .oDone    (calc_done),
    .oWidthUs (calc_width)
  );

  always_comb begin
    pre_d        = tick ? '0 : pre_q + PRE_W'(1);
    us_d         = us_q;
    pend_width_d = pend_width_q;
    pend_en_d    = pend_en_q;
    width_d      = width_q;
    en_d         = en_q;

    if (tick) begin
      us_d = (us_q == US_W'(FRAME_US - 1)) ? '0 : us_q + US_W'(1);
    end
    if (sample) begin
      pend_en_d = iEnable;
    end
    if (calc_done) begin
      pend_width_d = calc_width;
    end
    if (boundary) begin
      width_d = pend_width_q;
      en_d    = pend_en_q;
    end

    // Compare against the values taking effect this clock so the rising edge
    // lines up with the frame strobe.
    pwm_d   = en_d && (32'(us_q) < 32'(width_d));
    frame_d = boundary;
  end

  always_ff @(posedge Clk) begin
    if (!iRst_n) begin
      pre_q        <= '0;
      us_q         <= '0;
      pwm_q        <= 1'b0;
      frame_q      <= 1'b0;
      width_q      <= WIDTH_W'(NEUTRAL_US);
      en_q         <= 1'b1;
      pend_width_q <= WIDTH_W'(NEUTRAL_US);
      pend_en_q    <= 1'b1;
    end else begin
      pre_q        <= pre_d;
      us_q         <= us_d;
      pwm_q        <= pwm_d;
      frame_q      <= frame_d;
      width_q      <= width_d;
      en_q         <= en_d;
      pend_width_q <= pend_width_d;
      pend_en_q    <= pend_en_d;
    end
  end

  assign oPwm     = pwm_q;
  assign oFrame   = frame_q;
  assign oWidthUs = width_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb/tb_servo_pwm_gen.sv - self-checking bench for servo_pwm_gen and its width calculator

module tb_servo_pwm_gen;

  localparam int CLK_HZ     = 32_000_000;
  localparam int TICK       = CLK_HZ / 1_000_000;
  localparam int FRAME_US   = 120;
  localparam int MIN_US     = 10;
  localparam int MAX_US     = 100;
  localparam int MAX_ANG    = 180;
  localparam int NEUT_US    = 55;
  localparam int FRAME_CLKS = FRAME_US * TICK;
  localparam int SAMPLE_OFF = (FRAME_US - 1) * TICK;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en;
  logic [7:0]  ang;
  logic        pwm;
  logic        frame;
  logic [11:0] width_us;

  logic        c_rst_n;
  logic        c_start;
  logic [7:0]  c_ang;
  logic        c_done;
  logic [11:0] c_width;

  servo_pwm_gen #(
    .CLK_HZ       (CLK_HZ),
    .FRAME_US     (FRAME_US),
    .MIN_PULSE_US (MIN_US),
    .MAX_PULSE_US (MAX_US),
    .MAX_ANGLE    (MAX_ANG),
    .NEUTRAL_US   (NEUT_US)
  ) dut (
    .Clk      (clk),
    .iRst_n   (rst_n),
    .iAngle   (ang),
    .iEnable  (en),
    .oPwm     (pwm),
    .oFrame   (frame),
    .oWidthUs (width_us)
  );

  servo_width_calc u_calc (
    .Clk      (clk),
    .iRst_n   (c_rst_n),
    .iStart   (c_start),
    .iAngle   (c_ang),
    .oDone    (c_done),
    .oWidthUs (c_width)
  );

  int checks   = 0;
  int failures = 0;

  int         exp_w;
  logic       exp_en;
  logic [7:0] snap_a;
  logic       snap_e;

  typedef struct {
    logic [7:0] angle;
    int         exp_us;
  } calc_vec_t;

  calc_vec_t vecs[10];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int width_model(input int a, input int max_ang, input int min_us,
                                     input int max_us);
    int aa = (a > max_ang) ? max_ang : a;
    return min_us + (aa * (max_us - min_us)) / max_ang;
  endfunction

  task automatic calc_run(input logic [7:0] a, input int req, input string name);
    int lat = 0;
    @(negedge clk);
    c_ang   = a;
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    c_ang   = ~a;
    while (!c_done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s done_within_24", name), (c_done && lat <= 24) ? 1 : 0, 1);
    check($sformatf("%s width", name), int'(c_width), req);
  endtask

  // Runs one frame from its first clock. Expected envelope comes from exp_w/exp_en;
  // inputs present just before the sample point define the next frame.
  task automatic run_frame(input int chg_at, input logic [7:0] a, input logic e,
                           input int late_at, input logic [7:0] la, input logic le,
                           input int rst_at, input string name);
    int   strobe_bad = 0;
    int   shape_bad  = 0;
    int   width_bad  = 0;
    int   high_cnt   = 0;
    int   limit;
    int   exp_high;
    logic exp_p;
    limit = (rst_at >= 0) ? rst_at : FRAME_CLKS;
    for (int k = 0; k < limit; k++) begin
      exp_p = exp_en && (k < exp_w * TICK);
      if (frame !== (k == 0)) strobe_bad++;
      if (pwm !== exp_p) shape_bad++;
      if (pwm === 1'b1) high_cnt++;
      if (width_us !== 12'(exp_w)) width_bad++;
      if (k == chg_at) begin
        ang = a;
        en  = e;
      end
      if (k == late_at) begin
        ang = la;
        en  = le;
      end
      if (k == SAMPLE_OFF - 1) begin
        snap_a = ang;
        snap_e = en;
      end
      @(negedge clk);
    end
    exp_high = exp_en ? ((exp_w * TICK < limit) ? exp_w * TICK : limit) : 0;
    check($sformatf("%s frame_strobe_errs", name), strobe_bad, 0);
    check($sformatf("%s pwm_shape_errs", name), shape_bad, 0);
    check($sformatf("%s width_errs", name), width_bad, 0);
    check($sformatf("%s pwm_high_clks", name), high_cnt, exp_high);
    if (rst_at >= 0) begin
      rst_n = 1'b0;
      @(negedge clk);
      check($sformatf("%s rst_pwm", name), int'(pwm), 0);
      check($sformatf("%s rst_frame", name), int'(frame), 0);
      check($sformatf("%s rst_width", name), int'(width_us), NEUT_US);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_w  = NEUT_US;
      exp_en = 1'b1;
    end else begin
      exp_w  = width_model(int'(snap_a), MAX_ANG, MIN_US, MAX_US);
      exp_en = snap_e;
    end
  endtask

  initial begin
    int   early;
    int   lat;
    int   ra;
    logic re;

    vecs[0] = '{8'd0,   500};
    vecs[1] = '{8'd1,   511};
    vecs[2] = '{8'd45,  1000};
    vecs[3] = '{8'd90,  1500};
    vecs[4] = '{8'd180, 2500};
    vecs[5] = '{8'd200, 2500};
    vecs[6] = '{8'd30,  833};
    vecs[7] = '{8'd150, 2166};
    vecs[8] = '{8'd255, 2500};
    vecs[9] = '{8'd179, 2488};

    rst_n   = 1'b0;
    en      = 1'b1;
    ang     = 8'd90;
    c_rst_n = 1'b0;
    c_start = 1'b0;
    c_ang   = 8'd0;
    snap_a  = 8'd90;
    snap_e  = 1'b1;
    repeat (3) @(negedge clk);

    check("reset pwm", int'(pwm), 0);
    check("reset frame", int'(frame), 0);
    check("reset width", int'(width_us), NEUT_US);

    // Converter at default parameters.
    c_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      calc_run(vecs[i].angle, vecs[i].exp_us, $sformatf("calc_vec%0d", i));
    end

    // Restart while busy: only the second request may complete.
    @(negedge clk);
    c_ang   = 8'd10;
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    early   = 0;
    repeat (5) begin
      @(negedge clk);
      if (c_done) early++;
    end
    c_ang   = 8'd180;
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    lat     = 0;
    while (!c_done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("restart early_done", early, 0);
    check("restart done_within_24", (c_done && lat <= 24) ? 1 : 0, 1);
    check("restart width", int'(c_width), 2500);

    for (int i = 0; i < 16; i++) begin
      ra = int'($urandom_range(0, 255));
      calc_run(8'(ra), width_model(ra, 180, 500, 2500), $sformatf("calc_rand%0d", i));
    end

    check("reset held pwm", int'(pwm), 0);
    check("reset held width", int'(width_us), NEUT_US);

    // Release: first frame starts on the next clock with the neutral width.
    rst_n  = 1'b1;
    @(negedge clk);
    exp_w  = NEUT_US;
    exp_en = 1'b1;

    run_frame(5,    8'd90,  1'b1, -1, 8'd0, 1'b0, -1, "f_neutral");
    run_frame(40,   8'd0,   1'b1, -1, 8'd0, 1'b0, -1, "f_90");
    run_frame(SAMPLE_OFF - 1, 8'd180, 1'b1, -1, 8'd0, 1'b0, -1, "f_0");
    run_frame(7,    8'd200, 1'b1, -1, 8'd0, 1'b0, -1, "f_180");
    run_frame(300,  8'd45,  1'b0, -1, 8'd0, 1'b0, -1, "f_200");
    run_frame(900,  8'd45,  1'b1, -1, 8'd0, 1'b0, -1, "f_disabled");
    run_frame(100,  8'd30,  1'b1, SAMPLE_OFF, 8'd150, 1'b1, -1, "f_reenabled");
    run_frame(-1,   8'd0,   1'b0, -1, 8'd0, 1'b0, -1, "f_30_kept");
    run_frame(10,   8'd90,  1'b1, -1, 8'd0, 1'b0, -1, "f_150");

    for (int i = 0; i < 6; i++) begin
      ra = int'($urandom_range(0, 255));
      re = ($urandom_range(0, 3) != 0);
      run_frame(int'($urandom_range(0, FRAME_CLKS - 1)), 8'(ra), re, -1, 8'd0, 1'b0, -1,
                $sformatf("f_rand%0d", i));
    end

    run_frame(10,   8'd180, 1'b1, -1, 8'd0, 1'b0, -1, "f_pre_rst");
    run_frame(-1,   8'd0,   1'b0, -1, 8'd0, 1'b0, 1000, "f_rst_mid_pulse");
    run_frame(-1,   8'd0,   1'b0, -1, 8'd0, 1'b0, SAMPLE_OFF + 4, "f_rst_mid_div");
    run_frame(20,   8'd0,   1'b1, -1, 8'd0, 1'b0, -1, "f_after_rst");
    run_frame(-1,   8'd0,   1'b0, -1, 8'd0, 1'b0, -1, "f_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
